ram_arbiter2: RTL
=================

Name: ram_arbiter2

Overview:
- Synchronous controller that shares one async_ram256x8 (tri-state data bus, active-high we/oe) between two requesters.
- Arbitrates round-robin and serialises accesses.
- Generates setup/pulse/hold timing for writes and an oe window plus capture for reads.
- Sits between on-chip synchronous clients and the asynchronous RAM device.

Parameters:
- AW, 8, address width.
- DW, 8, data width.
- WE_W, 1, we pulse width in clk cycles (>=1).
- RD_WAIT, 1, extra cycles oe stays high before read capture (>=0).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req0, req1  in  1  access request, level; held until the matching ack.
- rw0, rw1  in  1  1 = write, 0 = read; stable while req is high.
- addr0, addr1  in  AW  access address.
- wdata0, wdata1  in  DW  write data.
- ack0, ack1  out  1  one-cycle completion pulse.
- rdata  out  DW  last read data; valid when ack of a read is high; held until the next read completes.
- ram_a  out  AW  RAM address lines.
- ram_d  inout  DW  RAM data lines; driven only in write states, otherwise z.
- ram_we  out  1  RAM write enable.
- ram_oe  out  1  RAM output enable.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high: reset=1 at a clk edge forces state=IDLE, ram_we=0, ram_oe=0, ram_d=z, ram_a=0, ack0=ack1=0, rdata=0, last=1.
- Reset mid-operation aborts the access at that edge. No ack is issued for it. Contents of the aborted write address are undefined.
- All outputs are registered. ram_we and ram_oe are never both 1.
- States and transitions:
  - IDLE: if any req, grant, latch addr/rw/wdata of the winner into internal registers, update last. Go to W_SETUP (write) or R_OE (read).
  - W_SETUP (1 cycle): ram_a = addr, ram_d driven with data, ram_we=0.
  - W_PULSE (WE_W cycles): ram_we=1, address and data unchanged.
  - W_HOLD (1 cycle): ram_we=0, ram_d still driven, address unchanged.
  - R_OE (RD_WAIT+1 cycles): ram_oe=1, ram_a = addr. On the last cycle, rdata <= ram_d.
  - DONE (1 cycle): ack of the granted port = 1, ram_oe=0, ram_d=z. Always returns to IDLE.
- Latency, grant edge to ack high: write 3+WE_W cycles; read 2+RD_WAIT cycles. Back-to-back throughput is one access per (latency+1) cycles.
- Handshake: the requester samples ack at a clk edge and drops or changes req at that same edge. req is therefore low in the IDLE that follows, so the same request is never served twice.
- Arbitration (round-robin):
  - Only one request: serve it.
  - Both requesting: serve the port != last.
  - last = index of the most recently granted port; reset value 1, so port 0 wins the first tie.
- The latched request is immune to input changes after grant.
- A req that deasserts before its ack is a protocol violation; the controller still completes the latched access.

Decomposition:
- Header ram_arbiter2_defs.vh: state encoding localparams (IDLE, W_SETUP, W_PULSE, W_HOLD, R_OE, DONE) and the width of the cycle counter used for WE_W/RD_WAIT.
- Sub-module rr_arb2: inputs req0, req1, last; outputs gnt_valid and gnt_idx. Purely combinational; the last register lives in the parent.
- Parent holds the FSM, the cycle counter, the latched request, rdata and the tri-state driver for ram_d.

Test Plan:
- Bench uses async_ram256x8 with default parameters.
- Port 0 writes addr 0x10 data 0xA5 -> ram_we high exactly 1 cycle, preceded and followed by one cycle of stable ram_a=0x10 and ram_d=0xA5; ack0 high 4 cycles after grant.
- Port 1 reads 0x10 after that write -> ram_oe high 2 cycles; rdata=0xA5 when ack1=1; ram_d z outside write states.
- req0 and req1 both rise in the same cycle (writes of 0x11 and 0x22 to 0x20 and 0x21), held until ack -> port 0 served first, then port 1. Readback gives 0x20=0x11, 0x21=0x22.
- Both ports request continuously for 6 accesses -> grants alternate 0,1,0,1,0,1; no ack on both ports in the same cycle.
- reset asserted in W_PULSE cycle -> next edge: ram_we=0, ram_d=z, state IDLE, no ack. A later read of 0x30 completes normally with correct latency.
- WE_W=3, RD_WAIT=2 instance -> write ack at 6 cycles, read ack at 4 cycles. Data written at 0xFF (address wrap limit) reads back correctly.

Source files
------------

// File: rtl/ram_arbiter2_pkg.sv
// ram_arbiter2_pkg: shared FSM encoding and counter width for the RAM arbiter
package ram_arbiter2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        W_SETUP,
        W_PULSE,
        W_HOLD,
        R_OE,
        DONE
    } state_t;

    // wide enough for WE_W and RD_WAIT+1 up to 256 cycles
    localparam int CNT_W = 8;

    function automatic logic is_write_state(input state_t s);
        return s inside {W_SETUP, W_PULSE, W_HOLD};
    endfunction

endpackage

// File: rtl/ram_arbiter2_rr_arb2.sv
// rr_arb2: two-port round-robin grant; the port other than last wins a tie
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic gnt_valid,
    output logic gnt_idx
);

    assign gnt_valid = req0 | req1;
    assign gnt_idx   = req1 & (~req0 | ~last);

endmodule

// File: rtl/ram_arbiter2.sv
// ram_arbiter2: round-robin sharing of one async RAM between two synchronous requesters
module ram_arbiter2
    import ram_arbiter2_pkg::*;
#(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int WE_W    = 1,
    parameter int RD_WAIT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          rw0,
    input  logic          rw1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] ram_a,
    inout  wire  [DW-1:0] ram_d,
    output logic          ram_we,
    output logic          ram_oe
);

    state_t state, nxt;
    logic [CNT_W-1:0] cnt;
    logic last, gnt_valid, gnt_idx;
    logic cur_idx, cur_rw;
    logic [AW-1:0] cur_a;
    logic [DW-1:0] cur_d;
    logic sel_idx, sel_rw;
    logic [AW-1:0] sel_a;
    logic [DW-1:0] sel_d;
    logic we_n, oe_n, drv_n, ack0_n, ack1_n;
    logic [AW-1:0] a_n;
    logic drive;
    logic [DW-1:0] dout;

    rr_arb2 u_arb (
        .req0      (req0),
        .req1      (req1),
        .last      (last),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // in IDLE the access about to start comes straight from the winner's inputs
    always_comb begin
        sel_idx = (state == IDLE) ? gnt_idx : cur_idx;
        sel_rw  = (state == IDLE) ? (gnt_idx ? rw1 : rw0) : cur_rw;
        sel_a   = (state == IDLE) ? (gnt_idx ? addr1 : addr0) : cur_a;
        sel_d   = (state == IDLE) ? (gnt_idx ? wdata1 : wdata0) : cur_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            last    <= 1'b1;
            cur_idx <= 1'b0;
            cur_rw  <= 1'b0;
            cur_a   <= '0;
            cur_d   <= '0;
        end else begin
            state <= nxt;
            cnt   <= (nxt == state) ? cnt + 1'b1 : '0;
            if (state == IDLE && gnt_valid) begin
                cur_idx <= gnt_idx;
                last    <= gnt_idx;
                cur_rw  <= sel_rw;
                cur_a   <= sel_a;
                cur_d   <= sel_d;
            end
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = gnt_valid ? (sel_rw ? W_SETUP : R_OE) : IDLE;
            W_SETUP: nxt = W_PULSE;
            W_PULSE: nxt = (cnt == CNT_W'(WE_W - 1)) ? W_HOLD : W_PULSE;
            W_HOLD:  nxt = DONE;
            R_OE:    nxt = (cnt == CNT_W'(RD_WAIT)) ? DONE : R_OE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // outputs are decoded from the next state so the registered pins line up with the state
    always_comb begin
        we_n   = nxt == W_PULSE;
        oe_n   = nxt == R_OE;
        drv_n  = is_write_state(nxt);
        ack0_n = nxt == DONE && !sel_idx;
        ack1_n = nxt == DONE && sel_idx;
        a_n    = (nxt == IDLE) ? ram_a : sel_a;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ram_we <= 1'b0;
            ram_oe <= 1'b0;
            drive  <= 1'b0;
            dout   <= '0;
            ram_a  <= '0;
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            rdata  <= '0;
        end else begin
            ram_we <= we_n;
            ram_oe <= oe_n;
            drive  <= drv_n;
            dout   <= sel_d;
            ram_a  <= a_n;
            ack0   <= ack0_n;
            ack1   <= ack1_n;
            if (state == R_OE && nxt == DONE)
                rdata <= ram_d;
        end
    end

    assign ram_d = drive ? dout : 'z;

endmodule
